// File: rtl/mips_mem_stage_if.sv
// Request/response bundle between the execute-side requester and the MIPS memory stage.
interface mips_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        addr_err;
  logic        link_valid;
  logic [31:0] link_addr;

  modport master (
    output req_valid, opcode, addr, wdata,
    input  req_ready, resp_valid, rdata, addr_err, link_valid, link_addr
  );

  modport slave (
    input  req_valid, opcode, addr, wdata,
    output req_ready, resp_valid, rdata, addr_err, link_valid, link_addr
  );
endinterface

// File: rtl/mips_mem_stage.sv
// MIPS memory stage: 64-word big-endian data store with byte/half/word access and an LL reservation.
//
// state | meaning
// IDLE  | ready for a request
// RD    | read addressed word (loads, and the read half of SB/SH merges)
// WR    | write merged word, drop a matching LL reservation
// RESP  | one-cycle completion pulse with rdata/addr_err
module mips_mem_stage (
  input  logic             clk,
  input  logic             rst_n,
  mips_mem_stage_if.slave  bus
);
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        mis_q;
  logic        bad_q;
  logic        link_valid_q;
  logic [31:0] link_addr_q;
  logic [31:0] mem [64];

  logic        in_known;
  logic        in_mis;
  logic        accept;
  logic [31:0] wr_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    in_known = 1'b0;
    in_mis   = 1'b0;
    case (bus.opcode)
      OP_SB, OP_LBU:        in_known = 1'b1;
      OP_SH, OP_LHU: begin
        in_known = 1'b1;
        in_mis   = bus.addr[0];
      end
      OP_SW, OP_LW, OP_LL: begin
        in_known = 1'b1;
        in_mis   = (bus.addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!in_known || in_mis)     state_nxt = RESP;
          else if (bus.opcode == OP_SW) state_nxt = WR;
          else                          state_nxt = RD;
        end
      end
      RD:      state_nxt = (op_q == OP_SB || op_q == OP_SH) ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      mis_q        <= 1'b0;
      bad_q        <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= bus.opcode;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        mis_q   <= in_mis;
        bad_q   <= !in_known || in_mis;
      end
      if (state == RD) begin
        word_q <= mem[addr_q[7:2]];
        if (op_q == OP_LL) begin
          link_valid_q <= 1'b1;
          link_addr_q  <= {addr_q[31:2], 2'b00};
        end
      end
      if (state == WR && addr_q[7:2] == link_addr_q[7:2])
        link_valid_q <= 1'b0;
    end
  end

  // Sub-word stores merge into the word fetched during RD.
  always_comb begin
    wr_word = word_q;
    case (op_q)
      OP_SW: wr_word = wdata_q;
      OP_SB: begin
        case (addr_q[1:0])
          2'd0: wr_word[31:24] = wdata_q[7:0];
          2'd1: wr_word[23:16] = wdata_q[7:0];
          2'd2: wr_word[15:8]  = wdata_q[7:0];
          default: wr_word[7:0] = wdata_q[7:0];
        endcase
      end
      OP_SH: begin
        if (addr_q[1]) wr_word[15:0]  = wdata_q[15:0];
        else           wr_word[31:16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  // Memory is deliberately not reset; async reset leaves IDLE so no write follows.
  always_ff @(posedge clk) begin
    if (state == WR)
      mem[addr_q[7:2]] <= wr_word;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = word_q[31:24];
      2'd1:    rd_byte = word_q[23:16];
      2'd2:    rd_byte = word_q[15:8];
      default: rd_byte = word_q[7:0];
    endcase
    rd_half = addr_q[1] ? word_q[15:0] : word_q[31:16];
  end

  always_comb begin
    bus.rdata = '0;
    if (state == RESP && !bad_q) begin
      case (op_q)
        OP_LW, OP_LL: bus.rdata = word_q;
        OP_LBU:       bus.rdata = {24'h0, rd_byte};
        OP_LHU:       bus.rdata = {16'h0, rd_half};
        default:      bus.rdata = '0;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.addr_err   = (state == RESP) && mis_q;
  assign bus.link_valid = link_valid_q;
  assign bus.link_addr  = link_addr_q;
endmodule

// File: tb/tb_mips_mem_stage.sv
// Self-checking bench for mips_mem_stage: directed scenarios plus random traffic against a byte-array model.
module tb_mips_mem_stage;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;

  logic clk;
  logic rst_n;
  mips_mem_stage_if bus ();

  mips_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: memory as 256 big-endian bytes, plus the reservation.
  logic [7:0]  mb [256];
  bit          m_lv;
  logic [31:0] m_la;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  {31'h0, bus.req_ready},  32'h1);
    check({tag, "_resp"},   {31'h0, bus.resp_valid}, 32'h0);
    check({tag, "_rdata"},  bus.rdata,               32'h0);
    check({tag, "_err"},    {31'h0, bus.addr_err},   32'h0);
    check({tag, "_lvalid"}, {31'h0, bus.link_valid}, 32'h0);
    check({tag, "_laddr"},  bus.link_addr,           32'h0);
  endtask

  // Issue one request from IDLE and check its response against the model.
  task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got_rd);
    bit          known, mis;
    int          b, exp_lat, lat;
    logic [31:0] exp_rd;
    b       = int'(a[7:0]);
    known   = op inside {OP_SB, OP_SH, OP_SW, OP_LW, OP_LBU, OP_LHU, OP_LL};
    mis     = ((op == OP_SH || op == OP_LHU) && a[0]) ||
              ((op == OP_SW || op == OP_LW || op == OP_LL) && a[1:0] != 2'b00);
    exp_rd  = 32'h0;
    exp_lat = (!known || mis) ? 1 : (op == OP_SB || op == OP_SH) ? 3 : 2;
    if (known && !mis) begin
      case (op)
        OP_LW:  exp_rd = {mb[b], mb[b+1], mb[b+2], mb[b+3]};
        OP_LL: begin
          exp_rd = {mb[b], mb[b+1], mb[b+2], mb[b+3]};
          m_lv   = 1'b1;
          m_la   = {a[31:2], 2'b00};
        end
        OP_LBU: exp_rd = {24'h0, mb[b]};
        OP_LHU: exp_rd = {16'h0, mb[b], mb[b+1]};
        OP_SB:  mb[b] = wd[7:0];
        OP_SH: begin
          mb[b]   = wd[15:8];
          mb[b+1] = wd[7:0];
        end
        OP_SW: begin
          mb[b]   = wd[31:24];
          mb[b+1] = wd[23:16];
          mb[b+2] = wd[15:8];
          mb[b+3] = wd[7:0];
        end
        default: ;
      endcase
      if (op inside {OP_SB, OP_SH, OP_SW} && a[7:2] == m_la[7:2]) m_lv = 1'b0;
    end

    @(negedge clk);
    check("ready_before_req", {31'h0, bus.req_ready}, 32'h1);
    bus.opcode    = op;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", {31'h0, bus.resp_valid}, 32'h1);
    check("latency",   lat,                      exp_lat);
    check("rdata",     bus.rdata,                exp_rd);
    check("addr_err",  {31'h0, bus.addr_err},    {31'h0, mis});
    got_rd = bus.rdata;
    @(negedge clk);
    check("resp_one_cycle", {31'h0, bus.resp_valid}, 32'h0);
    check("rdata_idle",     bus.rdata,               32'h0);
    check("err_idle",       {31'h0, bus.addr_err},   32'h0);
    check("link_valid",     {31'h0, bus.link_valid}, {31'h0, m_lv});
    check("link_addr",      bus.link_addr,           m_la);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] w_before;
    logic [5:0]  ops_tab [9];
    int          accepts, resps;

    ops_tab = '{OP_LW, OP_LBU, OP_LHU, OP_LL, OP_SB, OP_SH, OP_SW, 6'h00, 6'h3f};
    m_lv = 1'b0;
    m_la = 32'h0;
    bus.req_valid = 1'b0;
    bus.opcode    = 6'h0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    rst_n = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value so the model is fully defined.
    for (int i = 0; i < 64; i++)
      do_req(OP_SW, {$urandom_range(0, 255), 24'h0} | (i << 2), $urandom, rd);

    do_req(OP_SW, 32'h10, 32'hDEADBEEF, rd);
    do_req(OP_LW, 32'h10, 32'h0, rd);
    check("req21_lw", rd, 32'hDEADBEEF);

    do_req(OP_SB, 32'h11, 32'h55, rd);
    do_req(OP_LW, 32'h10, 32'h0, rd);
    check("req22_lw", rd, 32'hDE55BEEF);
    do_req(OP_LBU, 32'h13, 32'h0, rd);
    check("req22_lbu", rd, 32'h000000EF);
    do_req(OP_LHU, 32'h12, 32'h0, rd);
    check("req22_lhu", rd, 32'h0000BEEF);

    do_req(OP_LW, 32'h12, 32'h0, rd);
    do_req(OP_SH, 32'h11, 32'hFFFF, rd);
    do_req(OP_LW, 32'h10, 32'h0, rd);
    check("req23_unchanged", rd, 32'hDE55BEEF);

    do_req(OP_LL, 32'h23, 32'h0, rd);
    check("req24_mis_ll", {31'h0, bus.link_valid}, 32'h0);
    do_req(OP_LL, 32'h20, 32'h0, rd);
    check("req24_ll_v", {31'h0, bus.link_valid}, 32'h1);
    check("req24_ll_a", bus.link_addr, 32'h20);
    do_req(OP_SB, 32'h22, 32'h77, rd);
    check("req24_clr", {31'h0, bus.link_valid}, 32'h0);
    do_req(OP_LL, 32'h20, 32'h0, rd);
    do_req(OP_SB, 32'h24, 32'h66, rd);
    check("req24_keep", {31'h0, bus.link_valid}, 32'h1);

    // Back-to-back LW with req_valid held: one accept every 3 cycles.
    accepts = 0;
    resps   = 0;
    @(negedge clk);
    bus.opcode    = OP_LW;
    bus.addr      = 32'h10;
    bus.req_valid = 1'b1;
    #1;
    for (int i = 0; i < 21; i++) begin
      if (bus.req_ready && bus.req_valid) accepts++;
      if (bus.resp_valid) begin
        resps++;
        check("b2b_rdata", bus.rdata, {mb[16], mb[17], mb[18], mb[19]});
        check("b2b_ready_low", {31'h0, bus.req_ready}, 32'h0);
      end
      if (i < 20) begin
        @(negedge clk);
        #1;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", accepts, 7);
    check("b2b_resps", resps, 7);
    @(negedge clk);

    // Async reset in the RD cycle of an SB.
    do_req(OP_LL, 32'h40, 32'h0, rd);
    w_before = {mb[64], mb[65], mb[66], mb[67]};
    @(negedge clk);
    bus.opcode    = OP_SB;
    bus.addr      = 32'h41;
    bus.wdata     = ~{24'h0, mb[65]};
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_rd");
    @(negedge clk);
    rst_n = 1'b1;
    m_lv = 1'b0;
    m_la = 32'h0;
    do_req(OP_LW, 32'h40, 32'h0, rd);
    check("rst_rd_word", rd, w_before);

    // Async reset during WR, before the writing edge.
    w_before = {mb[68], mb[69], mb[70], mb[71]};
    @(negedge clk);
    bus.opcode    = OP_SB;
    bus.addr      = 32'h44;
    bus.wdata     = ~{24'h0, mb[68]};
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_wr");
    @(negedge clk);
    rst_n = 1'b1;
    do_req(OP_LW, 32'h44, 32'h0, rd);
    check("rst_wr_word", rd, w_before);

    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_req(ops_tab[$urandom_range(0, 8)], a, $urandom, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
